// File: rtl/pipe_ctrl_if.sv
// Pipeline-controller bundle: stage stall requests and MEM exception info in,
// stall vector / flush / redirect and debug status out. PIPE_PERF_CNT_EN adds perf counters.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] last_exc_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, last_exc_o
`ifdef PIPE_PERF_CNT_EN
    , input perf_stall_cycles, perf_flush_count
`endif
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, last_exc_o
`ifdef PIPE_PERF_CNT_EN
    , output perf_stall_cycles, perf_flush_count
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Six-stage pipeline controller: stall merge, exception flush/redirect, post-flush guard,
// stall watchdog and last-cause capture. Optional perf counters under PIPE_PERF_CNT_EN.
module pipe_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter int          WDT_LIMIT  = 1024,
  parameter int          WDT_W      = 11
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);

  state_t             state_r, state_next_s;
  logic [WDT_W-1:0]   count_r, count_next_s;
  logic               stall_timeout_r;
  logic [31:0]        last_exc_r;
  logic               exc_valid_s;
  logic [5:0]         stall_s;
  logic               flush_s;
  logic [31:0]        new_pc_s;

  function automatic logic [31:0] redirect_pc(input logic [31:0] exc, input logic [31:0] epc);
    case (exc)
      32'h0000_0001: redirect_pc = INT_VECTOR;
      32'h0000_000E: redirect_pc = epc;
      default:       redirect_pc = EXC_VECTOR;
    endcase
  endfunction

  // MEM holds a bubble right after a flush, so its exception field is not trusted in GUARD
  assign exc_valid_s = (bus.excepttype_i != 32'h0) && (state_r != GUARD);

  // Same-cycle stall/flush/redirect decode; exceptions outrank every stall request
  always_comb begin
    stall_s  = 6'b000000;
    flush_s  = 1'b0;
    new_pc_s = 32'h0;
    if (rst) begin
      stall_s  = 6'b000000;
    end else if (exc_valid_s) begin
      flush_s  = 1'b1;
      new_pc_s = redirect_pc(bus.excepttype_i, bus.cp0_epc_i);
    end else if (bus.stallreq_mem) begin
      stall_s  = 6'b011111;
    end else if (bus.stallreq_ex) begin
      stall_s  = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall_s  = 6'b000111;
    end else if (bus.stallreq_if) begin
      stall_s  = 6'b000011;
    end else begin
      stall_s  = 6'b000000;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = RUN;
    case (state_r)
      RUN, STALL: begin
        if (exc_valid_s) begin
          state_next_s = GUARD;
        end else if (stall_s != 6'b000000) begin
          state_next_s = STALL;
        end else begin
          state_next_s = RUN;
        end
      end
      GUARD: begin
        if (stall_s != 6'b000000) begin
          state_next_s = STALL;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // Watchdog counts unbroken stalled cycles and saturates at the limit
  always_comb begin
    count_next_s = count_r;
    if (flush_s || (stall_s == 6'b000000)) begin
      count_next_s = {WDT_W{1'b0}};
    end else if (count_r == WDT_MAX) begin
      count_next_s = count_r;
    end else begin
      count_next_s = count_r + WDT_W'(1);
    end
  end

  // State, watchdog and debug-capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= RUN;
      count_r         <= {WDT_W{1'b0}};
      stall_timeout_r <= 1'b0;
      last_exc_r      <= 32'h0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      if (count_next_s == WDT_MAX) begin
        stall_timeout_r <= 1'b1;
      end
      if (exc_valid_s) begin
        last_exc_r <= bus.excepttype_i;
      end
    end
  end

  assign bus.stall         = stall_s;
  assign bus.flush         = flush_s;
  assign bus.new_pc        = new_pc_s;
  assign bus.stall_timeout = stall_timeout_r;
  assign bus.last_exc_o    = last_exc_r;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles_r;
  logic [31:0] perf_flush_count_r;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles_r <= 32'h0;
      perf_flush_count_r  <= 32'h0;
    end else begin
      if (stall_s != 6'b000000) begin
        perf_stall_cycles_r <= perf_stall_cycles_r + 32'd1;
      end
      if (flush_s) begin
        perf_flush_count_r <= perf_flush_count_r + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cycles = perf_stall_cycles_r;
  assign bus.perf_flush_count  = perf_flush_count_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table plus hand sequences for watchdog and mid-state reset.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.WDT_LIMIT(8), .WDT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  req;     // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] last;
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] last;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];
  int compared = 0;
  int mismatched = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp({e.name, ".stall"}, {26'h0, bus.stall}, {26'h0, e.stall});
      cmp({e.name, ".flush"}, {31'h0, bus.flush}, {31'h0, e.flush});
      cmp({e.name, ".new_pc"}, bus.new_pc, e.pc);
      cmp({e.name, ".last_exc"}, bus.last_exc_o, e.last);
      cmp({e.name, ".timeout"}, {31'h0, bus.stall_timeout}, {31'h0, e.tmo});
    end
  endtask

  task automatic step(input string nm, input logic r, input logic [3:0] req,
                      input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input logic [31:0] el, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.stallreq_mem = req[3];
    bus.stallreq_ex  = req[2];
    bus.stallreq_id  = req[1];
    bus.stallreq_if  = req[0];
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    e.name = nm; e.stall = es; e.flush = ef; e.pc = ep; e.last = el; e.tmo = et;
    sb.push_back(e);
    check_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0;
    bus.excepttype_i = 32'h0; bus.cp0_epc_i = 32'h0;

    //          req    exc           epc           stall      fl    pc            last
    vecs[0]  = '{4'h0, 32'h0,        32'h0,        6'b000000, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{4'h1, 32'h0,        32'h0,        6'b000011, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{4'h1, 32'h0,        32'h0,        6'b000011, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{4'hC, 32'h0,        32'h0,        6'b011111, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{4'h0, 32'h0,        32'h0,        6'b000000, 1'b0, 32'h0,        32'h0};
    vecs[5]  = '{4'h2, 32'h0,        32'h0,        6'b000111, 1'b0, 32'h0,        32'h0};
    vecs[6]  = '{4'h8, 32'hC,        32'h0,        6'b000000, 1'b1, 32'h40,       32'h0};
    vecs[7]  = '{4'h0, 32'h0,        32'h0,        6'b000000, 1'b0, 32'h0,        32'hC};
    vecs[8]  = '{4'h0, 32'hE,        32'h1234,     6'b000000, 1'b1, 32'h1234,     32'hC};
    vecs[9]  = '{4'h0, 32'h1,        32'h1234,     6'b000000, 1'b0, 32'h0,        32'hE};
    vecs[10] = '{4'h0, 32'h1,        32'h1234,     6'b000000, 1'b1, 32'h20,       32'hE};
    vecs[11] = '{4'h4, 32'h8,        32'h0,        6'b001111, 1'b0, 32'h0,        32'h1};
    vecs[12] = '{4'h0, 32'h8,        32'h0,        6'b000000, 1'b1, 32'h40,       32'h1};
    vecs[13] = '{4'h1, 32'hA,        32'h0,        6'b000011, 1'b0, 32'h0,        32'h8};
    vecs[14] = '{4'h0, 32'hD,        32'h0,        6'b000000, 1'b1, 32'h40,       32'h8};
    vecs[15] = '{4'h0, 32'h0,        32'h0,        6'b000000, 1'b0, 32'h0,        32'hD};
    vecs[16] = '{4'h0, 32'h1F,       32'h0,        6'b000000, 1'b1, 32'h40,       32'hD};
    vecs[17] = '{4'h0, 32'h0,        32'h0,        6'b000000, 1'b0, 32'h0,        32'h1F};
    vecs[18] = '{4'hF, 32'h1,        32'h0,        6'b000000, 1'b1, 32'h20,       32'h1F};
    vecs[19] = '{4'h0, 32'h0,        32'h0,        6'b000000, 1'b0, 32'h0,        32'h1};

    // Outputs are forced quiet while rst is high, even with live requests
    step("rst0", 1'b1, 4'hF, 32'h1, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0, 1'b0);
    step("rst1", 1'b1, 4'hF, 32'h1, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), 1'b0, vecs[i].req, vecs[i].exc, vecs[i].epc,
           vecs[i].stall, vecs[i].flush, vecs[i].pc, vecs[i].last, 1'b0);
    end

    // Watchdog: timeout visible from the 9th cycle (set on the 8th stalled edge), sticky after
    for (int k = 1; k <= 10; k++) begin
      step($sformatf("wdt%0d", k), 1'b0, 4'h2, 32'h0, 32'h0,
           6'b000111, 1'b0, 32'h0, 32'h1, (k >= 9));
    end
    for (int k = 0; k < 3; k++) begin
      step($sformatf("wdt_hold%0d", k), 1'b0, 4'h0, 32'h0, 32'h0,
           6'b000000, 1'b0, 32'h0, 32'h1, 1'b1);
    end

    // Reset clears sticky flag and capture register on its edge
    step("rst_tmo", 1'b1, 4'h2, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h1, 1'b1);
    step("post_rst", 1'b0, 4'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset mid-stall with count=5: a stale count would trip the watchdog early
    for (int k = 1; k <= 5; k++) begin
      step($sformatf("pre%0d", k), 1'b0, 4'h2, 32'h0, 32'h0,
           6'b000111, 1'b0, 32'h0, 32'h0, 1'b0);
    end
    step("rst_stall", 1'b1, 4'h2, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0, 1'b0);
    step("after_rst", 1'b0, 4'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    cmp("perf_stall_after_rst", bus.perf_stall_cycles, 32'h0);
    cmp("perf_flush_after_rst", bus.perf_flush_count, 32'h0);
`endif
    for (int k = 1; k <= 9; k++) begin
      step($sformatf("post%0d", k), 1'b0, 4'h2, 32'h0, 32'h0,
           6'b000111, 1'b0, 32'h0, 32'h0, (k >= 9));
    end

    // Reset mid-GUARD: next cycle is RUN, so an exception is taken immediately
    step("guard_flush", 1'b0, 4'h0, 32'hC, 32'h0, 6'b000000, 1'b1, 32'h40, 32'h0, 1'b1);
    step("rst_guard", 1'b1, 4'h0, 32'h1, 32'h0, 6'b000000, 1'b0, 32'h0, 32'hC, 1'b1);
    step("run_exc", 1'b0, 4'h0, 32'h1, 32'h0, 6'b000000, 1'b1, 32'h20, 32'h0, 1'b0);
    step("run_idle", 1'b0, 4'h0, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 32'h1, 1'b0);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
